// File: rtl/debug_pkg.sv
// debug_pkg: shared definitions for the external-debug CSR block.
// Holds CSR addresses, debug cause encodings (shared with debug_controller),
// dcsr/mcontrol field positions, the step-FSM state type and the helpers
// that assemble the architectural read views of dcsr and mcontrol.
package debug_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_TSELECT   = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1    = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2    = 12'h7A2;
  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;

  // Debug cause encodings
  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  // dcsr field positions
  localparam int DCSR_EBREAKM   = 15;
  localparam int DCSR_STEP      = 2;
  localparam int DCSR_CAUSE_LSB = 6;

  // mcontrol field positions
  localparam int MC_DMODE      = 27;
  localparam int MC_ACTION_LSB = 12;
  localparam int MC_M          = 6;
  localparam int MC_EXECUTE    = 2;

  // Trigger array is sized to the architectural maximum so tselect can
  // index it without width games; unused slots read as zero.
  localparam int TRIG_MAX = 4;
  localparam int TSEL_W   = 2;

  typedef enum logic [1:0] {
    STEP_IDLE  = 2'd0,
    STEP_ARMED = 2'd1,
    STEP_FIRE  = 2'd2
  } step_state_e;

  // dcsr read view: xdebugver=4, prv=3 (M-mode), everything else zero.
  function automatic logic [31:0] dcsr_pack(input logic ebreakm,
                                            input logic [2:0] cause,
                                            input logic step);
    dcsr_pack = {4'd4, 12'd0, ebreakm, 6'd0, cause, 3'd0, step, 2'b11};
  endfunction

  // mcontrol read view: type=2, action is 0 or 1 only.
  function automatic logic [31:0] mcontrol_pack(input logic dmode,
                                                input logic action_one,
                                                input logic m,
                                                input logic execute);
    mcontrol_pack = {4'd2, dmode, 11'd0, 3'd0, action_one, 5'd0, m, 3'd0,
                     execute, 2'd0};
  endfunction

endpackage

// File: rtl/debug_trigger.sv
// debug_trigger: one mcontrol execute-address trigger.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   debug_mode_i          core halted; unlocks dmode-owned triggers
//   tdata1_we_i/2_we_i    write strobes already qualified by tselect
//   wdata_i               CSR write data
//   pc_i                  PC under comparison
//   tdata1_o/tdata2_o     read views
//   match_o               execute match on pc_i (unqualified by valid/mode)
module debug_trigger
  import debug_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            debug_mode_i,
  input  logic            tdata1_we_i,
  input  logic            tdata2_we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] tdata1_o,
  output logic [XLEN-1:0] tdata2_o,
  output logic            match_o
);

  logic            dmode_q;
  logic            action_one_q;  // action field is stored as a single 0/1 flag
  logic            m_q;
  logic            execute_q;
  logic [XLEN-1:0] tdata2_q;
  logic            locked_s;

  // A debugger-owned trigger cannot be touched by M-mode software.
  assign locked_s = dmode_q & ~debug_mode_i;

  // Trigger configuration registers with lock-qualified writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmode_q      <= 1'b0;
      action_one_q <= 1'b0;
      m_q          <= 1'b0;
      execute_q    <= 1'b0;
      tdata2_q     <= '0;
    end else begin
      if (tdata1_we_i && !locked_s) begin
        dmode_q      <= wdata_i[MC_DMODE];
        // Unsupported actions collapse to 0 (raise breakpoint exception).
        action_one_q <= (wdata_i[MC_ACTION_LSB +: 4] == 4'd1);
        m_q          <= wdata_i[MC_M];
        execute_q    <= wdata_i[MC_EXECUTE];
      end
      if (tdata2_we_i && !locked_s) begin
        tdata2_q <= wdata_i;
      end
    end
  end

  assign tdata1_o = XLEN'(mcontrol_pack(dmode_q, action_one_q, m_q, execute_q));
  assign tdata2_o = tdata2_q;
  assign match_o  = execute_q & m_q & action_one_q & (pc_i == tdata2_q);

endmodule

// File: rtl/debug_csr_unit.sv
// debug_csr_unit: RISC-V external-debug CSRs plus mcontrol triggers.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   csr_we_i/addr/wdata CSR write port; csr_rdata_o is the combinational read
//   pc_i, pc_valid_i    instruction at the trigger-compare stage
//   retire_i            one instruction committed
//   debug_mode_i        core halted in debug mode
//   save_dpc_i, debug_cause_i  capture pc_i into dpc and cause into dcsr
//   dret_i              leaving debug mode; arms single-step when dcsr.step=1
//   dpc_o, ebreakm_o    resume PC and dcsr.ebreakm
//   trigger_match_o     enabled trigger hits pc_i this cycle
//   single_step_o       step request to debug_controller
module debug_csr_unit
  import debug_pkg::*;
#(
  parameter int N_TRIGGERS = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  input  logic            retire_i,
  input  logic            debug_mode_i,
  input  logic            save_dpc_i,
  input  logic [2:0]      debug_cause_i,
  input  logic            dret_i,
  output logic [XLEN-1:0] dpc_o,
  output logic            ebreakm_o,
  output logic            trigger_match_o,
  output logic            single_step_o
);

  logic              ebreakm_q;
  logic              step_q;
  logic [2:0]        cause_q;
  logic [XLEN-1:0]   dpc_q;
  logic [XLEN-1:0]   dscratch0_q;
  logic [XLEN-1:0]   dscratch1_q;
  logic [TSEL_W-1:0] tselect_q;
  step_state_e       step_state_q;
  step_state_e       step_state_d;

  logic              dbg_we_s;
  logic [XLEN-1:0]   tdata1_s [TRIG_MAX];
  logic [XLEN-1:0]   tdata2_s [TRIG_MAX];
  logic [TRIG_MAX-1:0] match_s;

  // Debug-only registers accept writes only while halted.
  assign dbg_we_s = csr_we_i & debug_mode_i;

  // dcsr, dpc, dscratch and tselect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ebreakm_q   <= 1'b0;
      step_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      dpc_q       <= '0;
      dscratch0_q <= '0;
      dscratch1_q <= '0;
      tselect_q   <= '0;
    end else begin
      if (dbg_we_s && (csr_addr_i == CSR_DCSR)) begin
        ebreakm_q <= csr_wdata_i[DCSR_EBREAKM];
        step_q    <= csr_wdata_i[DCSR_STEP];
      end
      // Hardware capture has priority over a same-cycle software dpc write.
      if (save_dpc_i) begin
        dpc_q   <= {pc_i[XLEN-1:1], 1'b0};
        cause_q <= debug_cause_i;
      end else if (dbg_we_s && (csr_addr_i == CSR_DPC)) begin
        dpc_q   <= {csr_wdata_i[XLEN-1:1], 1'b0};
      end
      if (dbg_we_s && (csr_addr_i == CSR_DSCRATCH0)) begin
        dscratch0_q <= csr_wdata_i;
      end
      if (dbg_we_s && (csr_addr_i == CSR_DSCRATCH1)) begin
        dscratch1_q <= csr_wdata_i;
      end
      // Out-of-range selections are dropped so tselect always names a trigger.
      if (csr_we_i && (csr_addr_i == CSR_TSELECT) &&
          (csr_wdata_i < XLEN'(N_TRIGGERS))) begin
        tselect_q <= csr_wdata_i[TSEL_W-1:0];
      end
    end
  end

  for (genvar i = 0; i < TRIG_MAX; i++) begin : g_trig
    if (i < N_TRIGGERS) begin : g_on
      logic sel_s;
      assign sel_s = csr_we_i && (tselect_q == TSEL_W'(i));
      debug_trigger #(.XLEN(XLEN)) u_trig (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .debug_mode_i (debug_mode_i),
        .tdata1_we_i  (sel_s && (csr_addr_i == CSR_TDATA1)),
        .tdata2_we_i  (sel_s && (csr_addr_i == CSR_TDATA2)),
        .wdata_i      (csr_wdata_i),
        .pc_i         (pc_i),
        .tdata1_o     (tdata1_s[i]),
        .tdata2_o     (tdata2_s[i]),
        .match_o      (match_s[i])
      );
    end else begin : g_off
      assign tdata1_s[i] = '0;
      assign tdata2_s[i] = '0;
      assign match_s[i]  = 1'b0;
    end
  end

  // Combinational CSR read mux; unmapped addresses read zero.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_TSELECT:   csr_rdata_o = XLEN'(tselect_q);
      CSR_TDATA1:    csr_rdata_o = tdata1_s[tselect_q];
      CSR_TDATA2:    csr_rdata_o = tdata2_s[tselect_q];
      CSR_DCSR:      csr_rdata_o = XLEN'(dcsr_pack(ebreakm_q, cause_q, step_q));
      CSR_DPC:       csr_rdata_o = dpc_q;
      CSR_DSCRATCH0: csr_rdata_o = dscratch0_q;
      CSR_DSCRATCH1: csr_rdata_o = dscratch1_q;
      default:       csr_rdata_o = '0;
    endcase
  end

  // Step FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_state_q <= STEP_IDLE;
    end else begin
      step_state_q <= step_state_d;
    end
  end

  // Step FSM next state: dret re-decides from dcsr.step regardless of state.
  always_comb begin
    step_state_d = step_state_q;
    if (dret_i) begin
      step_state_d = step_q ? STEP_ARMED : STEP_IDLE;
    end else begin
      case (step_state_q)
        STEP_IDLE: step_state_d = STEP_IDLE;
        STEP_ARMED: begin
          if (retire_i && !debug_mode_i) begin
            step_state_d = STEP_FIRE;
          end else begin
            step_state_d = STEP_ARMED;
          end
        end
        STEP_FIRE: begin
          if (debug_mode_i) begin
            step_state_d = STEP_IDLE;
          end else begin
            step_state_d = STEP_FIRE;
          end
        end
        default: step_state_d = STEP_IDLE;
      endcase
    end
  end

  assign single_step_o   = (step_state_q == STEP_FIRE);
  assign dpc_o           = dpc_q;
  assign ebreakm_o       = ebreakm_q;
  assign trigger_match_o = pc_valid_i & ~debug_mode_i & (|match_s);

endmodule
